// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit: state encoding and default vectors.
package pc_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_HANDLER = 2'd1;
  localparam logic [1:0] ST_HALTED  = 2'd2;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, a push when full silently overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;    // next free slot; top entry sits just below it
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_top_idx;

  assign w_top_idx = r_ptr - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));

  always_ff @(negedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!o_full) r_count <= r_count + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(negedge i_clk) begin
    if (i_rst_n && i_push) r_mem[r_ptr] <= i_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC priority mux, run/handler/halted FSM, EPC and return stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH        = 32,
  parameter int unsigned       INC          = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic             i_call,
  input  logic [WIDTH-1:0] i_jump_target,
  input  logic             i_ret,
  input  logic [WIDTH-1:0] i_ret_target,
  input  logic             i_exc,
  input  logic             i_eret,
  input  logic             i_halt,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus_inc,
  output logic [WIDTH-1:0] o_epc,
  output logic             o_in_handler,
  output logic             o_halted,
  output logic             o_ras_empty,
  output logic             o_ras_full
);

  logic [WIDTH-1:0] r_pc, r_epc;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] w_pc_d, w_epc_d, w_pc_plus_inc, w_ras_top;
  logic [1:0]       w_state_d;
  logic             w_push, w_pop;

  assign w_pc_plus_inc = r_pc + WIDTH'(INC);

  always_comb begin
    w_pc_d    = r_pc;
    w_epc_d   = r_epc;
    w_state_d = r_state;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    if (r_state == ST_HALTED) begin
      w_state_d = ST_HALTED;
    end else if (i_halt) begin
      w_state_d = ST_HALTED;
    end else if (i_exc && r_state == ST_RUN) begin
      w_epc_d   = r_pc;
      w_pc_d    = EXC_VECTOR;
      w_state_d = ST_HANDLER;
    end else if (i_eret && r_state == ST_HANDLER) begin
      w_pc_d    = r_epc;
      w_state_d = ST_RUN;
    end else if (i_stall) begin
      w_pc_d = r_pc;
    end else if (i_ret) begin
      // An empty stack falls back to the register-supplied address without popping.
      if (o_ras_empty) begin
        w_pc_d = i_ret_target;
      end else begin
        w_pc_d = w_ras_top;
        w_pop  = 1'b1;
      end
    end else if (i_call) begin
      w_pc_d = i_jump_target;
      w_push = 1'b1;
    end else if (i_jump) begin
      w_pc_d = i_jump_target;
    end else if (i_branch_taken) begin
      w_pc_d = i_branch_target;
    end else begin
      w_pc_d = w_pc_plus_inc;
    end
  end

  always_ff @(negedge i_clk) begin
    if (!i_rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_epc   <= '0;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_d;
      r_epc   <= w_epc_d;
      r_state <= w_state_d;
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_plus_inc),
    .o_top   (w_ras_top),
    .o_empty (o_ras_empty),
    .o_full  (o_ras_full)
  );

  assign o_pc          = r_pc;
  assign o_pc_plus_inc = w_pc_plus_inc;
  assign o_epc         = r_epc;
  assign o_in_handler  = (r_state == ST_HANDLER);
  assign o_halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, hand sequences for the stack and wrap, random vs model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, br, jmp, call, ret, exc, eret, halt;
  logic [31:0] btgt, jtgt, rtgt;
  logic [31:0] pc, pc_plus, epc;
  logic        in_handler, halted, ras_empty, ras_full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_target (btgt),
    .i_jump          (jmp),
    .i_call          (call),
    .i_jump_target   (jtgt),
    .i_ret           (ret),
    .i_ret_target    (rtgt),
    .i_exc           (exc),
    .i_eret          (eret),
    .i_halt          (halt),
    .o_pc            (pc),
    .o_pc_plus_inc   (pc_plus),
    .o_epc           (epc),
    .o_in_handler    (in_handler),
    .o_halted        (halted),
    .o_ras_empty     (ras_empty),
    .o_ras_full      (ras_full)
  );

  // Control bit masks for the vector table.
  localparam logic [8:0] RST = 9'h001, STL = 9'h002, BR = 9'h004, JMP = 9'h008, CALL = 9'h010;
  localparam logic [8:0] RET = 9'h020, EXC = 9'h040, ERET = 9'h080, HALT = 9'h100;
  // Flag bits: {in_handler, halted, ras_empty, ras_full}.
  localparam logic [3:0] F_INH = 4'h8, F_HLT = 4'h4, F_E = 4'h2, F_F = 4'h1, F_NONE = 4'h0;

  typedef struct {
    logic [8:0]  ctrl;
    logic [31:0] btgt, jtgt, rtgt;
    logic [31:0] exp_pc, exp_epc;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [8:0] c, input logic [31:0] b, input logic [31:0] j,
                       input logic [31:0] r);
    rst_n = ~c[0]; stall = c[1]; br = c[2]; jmp = c[3]; call = c[4];
    ret = c[5]; exc = c[6]; eret = c[7]; halt = c[8];
    btgt = b; jtgt = j; rtgt = r;
  endtask

  // Inputs change at the rising edge; DUT updates on the falling edge; outputs are read next rise.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_epc,
                         input logic [3:0] f);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus_inc"}, pc_plus, e_pc + 32'd4);
    chk({tag, ".epc"}, epc, e_epc);
    chk({tag, ".flags"}, {28'd0, in_handler, halted, ras_empty, ras_full}, {28'd0, f});
  endtask

  // Reference model state: plain integers and a queue for the return stack.
  logic [31:0] m_pc, m_epc;
  bit          m_handler, m_halted;
  logic [31:0] m_ras[$];

  task automatic model_step();
    if (!rst_n) begin
      m_pc = 32'h0; m_epc = 32'h0; m_handler = 0; m_halted = 0; m_ras.delete();
    end else if (m_halted) begin
      // frozen
    end else if (halt) begin
      m_halted = 1; m_handler = 0;
    end else if (exc && !m_handler) begin
      m_epc = m_pc; m_pc = 32'h80; m_handler = 1;
    end else if (eret && m_handler) begin
      m_pc = m_epc; m_handler = 0;
    end else if (stall) begin
      // hold
    end else if (ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_pc = rtgt;
    end else if (call) begin
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > 4) m_ras.delete(0);
      m_pc = jtgt;
    end else if (jmp) begin
      m_pc = jtgt;
    end else if (br) begin
      m_pc = btgt;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    logic [3:0]  mf;
    logic [31:0] exp_ret;
    drive(RST, 0, 0, 0);

    vecs.push_back('{RST,        0,     0,     0,     32'h0,   32'h0,  F_E});
    vecs.push_back('{9'h0,       0,     0,     0,     32'h4,   32'h0,  F_E});
    vecs.push_back('{9'h0,       0,     0,     0,     32'h8,   32'h0,  F_E});
    vecs.push_back('{9'h0,       0,     0,     0,     32'hc,   32'h0,  F_E});
    vecs.push_back('{BR | JMP,   32'h40, 32'h100, 0,  32'h100, 32'h0,  F_E});
    vecs.push_back('{STL | BR,   32'h40, 0,     0,     32'h100, 32'h0,  F_E});
    vecs.push_back('{JMP,        0,     32'h10, 0,     32'h10,  32'h0,  F_E});
    vecs.push_back('{CALL,       0,     32'h200, 0,    32'h200, 32'h0,  F_NONE});
    vecs.push_back('{RET,        0,     0,     0,     32'h14,  32'h0,  F_E});
    vecs.push_back('{RET,        0,     0,     32'h300, 32'h300, 32'h0, F_E});
    vecs.push_back('{RET | CALL, 0,     32'h500, 32'h400, 32'h400, 32'h0, F_E});
    vecs.push_back('{JMP,        0,     32'h24, 0,     32'h24,  32'h0,  F_E});
    vecs.push_back('{EXC | STL,  0,     0,     0,     32'h80,  32'h24, F_INH | F_E});
    vecs.push_back('{EXC,        0,     0,     0,     32'h84,  32'h24, F_INH | F_E});
    vecs.push_back('{ERET | STL, 0,     0,     0,     32'h24,  32'h24, F_E});
    vecs.push_back('{ERET,       0,     0,     0,     32'h28,  32'h24, F_E});
    vecs.push_back('{HALT,       0,     0,     0,     32'h28,  32'h24, F_HLT | F_E});
    vecs.push_back('{JMP,        0,     32'h100, 0,    32'h28,  32'h24, F_HLT | F_E});
    vecs.push_back('{EXC,        0,     0,     0,     32'h28,  32'h24, F_HLT | F_E});
    vecs.push_back('{CALL,       0,     32'h300, 0,    32'h28,  32'h24, F_HLT | F_E});
    vecs.push_back('{RET | ERET, 0,     0,     32'h44, 32'h28,  32'h24, F_HLT | F_E});
    vecs.push_back('{9'h0,       0,     0,     0,     32'h28,  32'h24, F_HLT | F_E});
    vecs.push_back('{RST | JMP,  0,     32'h100, 0,    32'h0,   32'h0,  F_E});
    vecs.push_back('{EXC,        0,     0,     0,     32'h80,  32'h0,  F_INH | F_E});
    vecs.push_back('{HALT,       0,     0,     0,     32'h80,  32'h0,  F_HLT | F_E});
    vecs.push_back('{RST,        0,     0,     0,     32'h0,   32'h0,  F_E});

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctrl, vecs[i].btgt, vecs[i].jtgt, vecs[i].rtgt);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_epc, vecs[i].exp_flags);
    end

    // Five calls into a four-deep stack: oldest return address is lost.
    for (int i = 0; i < 5; i++) begin
      drive(CALL, 0, 32'(i + 1) << 12, 0);
      tick();
      mf = (i >= 3) ? F_F : F_NONE;
      chk_all($sformatf("call%0d", i), 32'(i + 1) << 12, 32'h0, mf);
    end
    for (int i = 4; i >= 1; i--) begin
      drive(RET, 0, 0, 32'h777);
      tick();
      exp_ret = (32'(i) << 12) + 32'd4;
      chk_all($sformatf("ret%0d", i), exp_ret, 32'h0, (i == 1) ? F_E : F_NONE);
    end
    drive(RET, 0, 0, 32'h777);
    tick();
    chk_all("ret_empty", 32'h777, 32'h0, F_E);

    // Sequential wrap at the top of the address space.
    drive(JMP, 0, 32'hFFFF_FFFC, 0);
    tick();
    chk("wrap.pc", pc, 32'hFFFF_FFFC);
    chk("wrap.pc_plus_inc", pc_plus, 32'h0);
    drive(9'h0, 0, 0, 0);
    tick();
    chk("wrap.next", pc, 32'h0);

    // Randomised run against the reference model.
    drive(RST, 0, 0, 0);
    model_step();
    tick();
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      halt  = ($urandom_range(0, 79) == 0);
      exc   = ($urandom_range(0, 7) == 0);
      eret  = ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 4) == 0);
      ret   = ($urandom_range(0, 4) == 0);
      call  = ($urandom_range(0, 3) == 0);
      jmp   = ($urandom_range(0, 4) == 0);
      br    = ($urandom_range(0, 3) == 0);
      btgt  = $urandom & 32'hFFFF_FFFC;
      jtgt  = $urandom & 32'hFFFF_FFFC;
      rtgt  = $urandom;
      model_step();
      tick();
      mf = {m_handler, m_halted, m_ras.size() == 0, m_ras.size() == 4};
      chk_all($sformatf("rnd%0d", n), m_pc, m_epc, mf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
